// File: rtl/regfile_seq_pkg.sv
// Shared types and register-field layout for the regfile sequencing controller.
// The ABORT state exists only when REGFILE_SEQ_TIMEOUT_EN is defined.
package regfile_seq_pkg;

  localparam int REG_FIELD_W = 5;
  localparam int RS1_OFS     = 10;
  localparam int RS2_OFS     = 5;
  localparam int RD_OFS      = 0;

  localparam logic [REG_FIELD_W-1:0] X0 = '0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RS1   = 3'd1,
    ST_RS2   = 3'd2,
    ST_ISSUE = 3'd3,
    ST_EXEC  = 3'd4,
`ifdef REGFILE_SEQ_TIMEOUT_EN
    ST_WB    = 3'd5,
    ST_ABORT = 3'd6
`else
    ST_WB    = 3'd5
`endif
  } seq_state_e;

endpackage

// File: rtl/regfile_seq_wdog.sv
// EXEC watchdog: counts enabled cycles and flags expiry in the last allowed cycle.
// Instantiated by regfile_seq_ctrl only when REGFILE_SEQ_TIMEOUT_EN is defined.
module regfile_seq_wdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q;

  // Count equals (EXEC cycle index - 1), so expiry lands in the final allowed cycle.
  assign expire = enable && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (enable && !expire) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Sequences one instruction through two register reads, ALU issue/exec and writeback.
// Optional EXEC watchdog with ABORT state enabled by defining REGFILE_SEQ_TIMEOUT_EN.
module regfile_seq_ctrl
  import regfile_seq_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 15,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [ADDR_WIDTH-1:0] instr_regs,
  input  logic [BUS_WIDTH-1:0]  instr_imm,
  input  logic                  instr_use_imm,
  input  logic                  instr_wb,
  output logic                  rs_addr_valid,
  output logic [ADDR_WIDTH-1:0] rs1_rs2_rd,
  output logic                  rs_store,
  input  logic [BUS_WIDTH-1:0]  rs_data,
  output logic [BUS_WIDTH-1:0]  imme_data,
  output logic [BUS_WIDTH-1:0]  rs_data_mux,
  output logic [BUS_WIDTH-1:0]  alu_op_a,
  output logic                  alu_start,
  input  logic                  alu_data_valid,
  input  logic [BUS_WIDTH-1:0]  alu_data_out,
  output logic                  rd_wr_en,
  output logic [BUS_WIDTH-1:0]  rd_wr_data,
  output logic                  op_done,
  output logic                  err
);

  seq_state_e state_q, state_d;

  logic                  exec_first_q;
  logic [ADDR_WIDTH-1:0] regs_q;
  logic [BUS_WIDTH-1:0]  imm_q;
  logic                  use_imm_q;
  logic                  wb_q;
  logic [BUS_WIDTH-1:0]  op_a_q;
  logic [BUS_WIDTH-1:0]  op_b_q;
  logic [BUS_WIDTH-1:0]  result_q;
  logic [REG_FIELD_W-1:0] rd_field;

  assign rd_field = regs_q[RD_OFS +: REG_FIELD_W];

`ifdef REGFILE_SEQ_TIMEOUT_EN
  logic timeout;

  regfile_seq_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != ST_EXEC),
    .enable (state_q == ST_EXEC),
    .expire (timeout)
  );
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (instr_valid) state_d = ST_RS1;
      ST_RS1:   state_d = ST_RS2;
      ST_RS2:   state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_EXEC;
      ST_EXEC: begin
        // A result in the final counted cycle takes priority over the watchdog.
        if (alu_data_valid) state_d = ST_WB;
`ifdef REGFILE_SEQ_TIMEOUT_EN
        else if (timeout)   state_d = ST_ABORT;
`endif
      end
      ST_WB:    state_d = ST_IDLE;
`ifdef REGFILE_SEQ_TIMEOUT_EN
      ST_ABORT: state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instr_ready   = (state_q == ST_IDLE);
    rs_addr_valid = (state_q == ST_RS1) || ((state_q == ST_RS2) && !use_imm_q);
    rs_store      = (state_q == ST_RS2);
    alu_start     = (state_q == ST_EXEC) && exec_first_q;
    // Writes to x0 are dropped; rd_wr_en is also gated off while rst is high.
    rd_wr_en      = (state_q == ST_WB) && wb_q && (rd_field != X0) && !rst;
`ifdef REGFILE_SEQ_TIMEOUT_EN
    op_done       = (state_q == ST_WB) || (state_q == ST_ABORT);
    err           = (state_q == ST_ABORT);
`else
    op_done       = (state_q == ST_WB);
    err           = 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      exec_first_q <= 1'b0;
      regs_q       <= '0;
      imm_q        <= '0;
      use_imm_q    <= 1'b0;
      wb_q         <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      exec_first_q <= (state_q == ST_ISSUE);
      if ((state_q == ST_IDLE) && instr_valid) begin
        regs_q    <= instr_regs;
        imm_q     <= instr_imm;
        use_imm_q <= instr_use_imm;
        wb_q      <= instr_wb;
      end
      // Read data trails its strobe by one cycle: rs1 arrives in RS2, rs2 in ISSUE.
      if (state_q == ST_RS2)   op_a_q <= rs_data;
      if (state_q == ST_ISSUE) op_b_q <= use_imm_q ? imm_q : rs_data;
      if ((state_q == ST_EXEC) && alu_data_valid) result_q <= alu_data_out;
    end
  end

  assign rs1_rs2_rd  = regs_q;
  assign imme_data   = imm_q;
  assign alu_op_a    = op_a_q;
  assign rs_data_mux = op_b_q;
  assign rd_wr_data  = result_q;

endmodule

// File: doc/regfile_seq_ctrl.md
REGFILE_SEQ_CTRL -- requirements
Module: regfile_seq_ctrl

Interface
REQ-001 Parameter BUS_WIDTH, default 32, operand and result data width.
REQ-002 Parameter ADDR_WIDTH, default 15, packed register-select width {rs1[14:10], rs2[9:5], rd[4:0]}.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, number of EXEC cycles allowed before abort.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clk, in, 1: sole clock, rising edge.
REQ-006 Port rst, in, 1: synchronous, active-high reset.
REQ-007 Ports instr_valid in 1 and instr_ready out 1: instruction handshake.
REQ-008 Ports instr_regs in ADDR_WIDTH, instr_imm in BUS_WIDTH, instr_use_imm in 1 and instr_wb in 1: register fields, immediate, operand-B-from-immediate select, and writeback request.
REQ-009 Port rs_addr_valid, out, 1: register-file read strobe.
REQ-010 Port rs1_rs2_rd, out, ADDR_WIDTH: latched register fields.
REQ-011 Port rs_store, out, 1: read slot select (0 = rs1, 1 = rs2).
REQ-012 Port rs_data, in, BUS_WIDTH: read data, valid 1 cycle after the strobe.
REQ-013 Ports imme_data and rs_data_mux, out, BUS_WIDTH: latched immediate, and operand B (rs2 or immediate).
REQ-014 Ports alu_op_a out BUS_WIDTH and alu_start out 1: operand A and one-cycle ALU launch pulse.
REQ-015 Ports alu_data_valid in 1 and alu_data_out in BUS_WIDTH: ALU result handshake.
REQ-016 Ports rd_wr_en out 1, rd_wr_data out BUS_WIDTH, op_done out 1 and err out 1: writeback strobe, writeback data, completion pulse and abort pulse.

Function
REQ-017 The FSM SHALL use states IDLE, RS1, RS2, ISSUE, EXEC and WB, plus ABORT when configured.
- IDLE to RS1 on handshake.
- RS1 to RS2, and RS2 to ISSUE, unconditionally.
- ISSUE to EXEC unconditionally.
- EXEC to WB on alu_data_valid.
- WB to IDLE.
REQ-018 instr_ready SHALL be 1 only in IDLE; the handshake SHALL latch instr_regs, instr_imm, instr_use_imm and instr_wb.
REQ-019 Read strobes:
- RS1: rs_addr_valid=1, rs_store=0.
- RS2: rs_store=1, with rs_addr_valid=!use_imm.
- All other states: rs_addr_valid=0.
REQ-020 The end of RS2 SHALL capture rs_data into alu_op_a; the end of ISSUE SHALL capture rs_data, or the immediate if use_imm, into rs_data_mux.
REQ-021 alu_start SHALL be 1 only in the first EXEC cycle; operands SHALL hold stable throughout EXEC.
REQ-022 alu_data_valid SHALL be sampled from the first EXEC cycle, including same-cycle results; the block SHALL capture alu_data_out into rd_wr_data.
REQ-023 alu_data_valid outside EXEC SHALL be ignored.
REQ-024 WB SHALL be exactly one cycle:
- op_done=1.
- rd_wr_en=1 only if instr_wb=1 and rd!=0.
- A write to x0 SHALL be suppressed while op_done still pulses.
REQ-025 Minimum latency SHALL be a 5-cycle op_done after the accepting edge.
REQ-026 The block SHALL process one instruction at a time; back-to-back acceptance is possible in the cycle after WB.

Reset
REQ-027 On rst, including mid-operation, the block SHALL enter IDLE next edge and abandon any pending write.
REQ-028 Reset values SHALL be:
- All outputs 0, except instr_ready=1.
- Latched registers 0.
REQ-029 During reset, rd_wr_en SHALL never be asserted.

Configuration
REQ-030 Macro REGFILE_SEQ_TIMEOUT_EN controls the EXEC watchdog.
REQ-031 With REGFILE_SEQ_TIMEOUT_EN defined:
- Count EXEC cycles.
- After TIMEOUT_CYCLES cycles without alu_data_valid, go to ABORT.
- ABORT is one cycle with err=1, op_done=1 and rd_wr_en=0, then IDLE.
- alu_data_valid in the final counted cycle wins over the timeout.
REQ-032 Without REGFILE_SEQ_TIMEOUT_EN: no ABORT state; EXEC waits indefinitely; err is tied to 0.

Structure
REQ-033 Package regfile_seq_pkg SHALL hold:
- The state enum.
- The RS1/RS2/RD field offsets and width (5).
- The X0 constant.
REQ-034 Sub-module regfile_seq_wdog (counter, clear, expire) SHALL exist, instantiated only under REGFILE_SEQ_TIMEOUT_EN.

Verification
REQ-035 Register-register add: regs={1,2,3}, rs_data rs1=5 then rs2=7, ALU returns 12 same cycle -> alu_op_a=5, rs_data_mux=7, rd_wr_en=1, rd_wr_data=12, op_done 5 cycles after accept.
REQ-036 Immediate op: use_imm=1, imm=0x10 -> no rs_addr_valid in RS2, rs_data_mux=0x10.
REQ-037 rd=0 with instr_wb=1 -> op_done=1, rd_wr_en=0.
REQ-038 Slow ALU with valid at EXEC cycle 4 -> alu_start one pulse, operands stable, and instr_ready=0 while busy.
REQ-039 rst asserted in EXEC -> IDLE next cycle and no write; a stray alu_data_valid in IDLE is ignored.
REQ-040 Under REGFILE_SEQ_TIMEOUT_EN with no alu_data_valid for 16 EXEC cycles -> err=1, op_done=1, no write, then IDLE.
